// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR decoder.
//  - nec_state_t : frame-decoder FSM states
//  - *_B         : NEC timing nominals as multiples of the 562.5 us burst
//  - tol_ok()    : is a measured width within a percentage of its nominal?
//  - max_ok()    : largest width that tol_ok() still accepts
package nec_ir_pkg;

    localparam int WCNT_W = 12;          // width counter bits (saturating)

    localparam int LEAD_MARK_B  = 16;
    localparam int LEAD_SPACE_B = 8;
    localparam int RPT_SPACE_B  = 4;
    localparam int BIT_MARK_B   = 1;
    localparam int ZERO_SPACE_B = 1;
    localparam int ONE_SPACE_B  = 3;
    localparam int STOP_MARK_B  = 1;
    localparam int IDLE_GAP_B   = 8;     // quiet-high time needed to leave WAIT_IDLE

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_RPT_STOP,
        S_DONE,
        S_WAIT_IDLE
    } nec_state_t;

    function automatic logic tol_ok(input logic [WCNT_W-1:0] w, input int nom, input int tol);
        int diff;
        diff = int'(w) - nom;
        if (diff < 0) diff = -diff;
        return (diff * 100) <= (nom * tol);
    endfunction

    function automatic int max_ok(input int nom, input int tol);
        return nom + (nom * tol) / 100;
    endfunction

endpackage

// File: rtl/nec_ir_width_meter.sv
// Front end of the NEC decoder: synchronises the raw IR line, optionally
// removes 1-tick glitches, detects edges and measures how long the line
// has been at its current level.
// Optional feature macro: IR_GLITCH_FILTER_EN (3-tap majority filter, +2 ticks latency).
// Ports:
//  clk    in   sample clock (rising edge)
//  reset  in   synchronous, active-high
//  ir_raw in   asynchronous receiver output, idle high
//  level  out  cleaned line level
//  fall   out  one-cycle pulse on the first low cycle of a mark
//  rise   out  one-cycle pulse on the first high cycle after a mark
//  width  out  cycles spent at the previous level; on fall/rise this is the
//              width of the mark/space that just ended; saturates at all-ones
module nec_ir_width_meter
    import nec_ir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_raw,
    output logic              level,
    output logic              fall,
    output logic              rise,
    output logic [WCNT_W-1:0] width
);

    logic sync_p0, sync_p1;
    logic cur, prev;

    // Stage 0/1: two-flop synchroniser, idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= ir_raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    logic tap_p2, tap_p3, flt_p4;

    // Stage 2..4: majority of three consecutive samples, registered
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_p2 <= 1'b1;
            tap_p3 <= 1'b1;
            flt_p4 <= 1'b1;
        end else begin
            tap_p2 <= sync_p1;
            tap_p3 <= tap_p2;
            flt_p4 <= (sync_p1 & tap_p2) | (sync_p1 & tap_p3) | (tap_p2 & tap_p3);
        end
    end

    assign cur = flt_p4;
`else
    assign cur = sync_p1;
`endif

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= cur;
    end

    assign level = cur;
    assign fall  = prev & ~cur;
    assign rise  = ~prev & cur;

    // Restart at 1 on each edge so the value seen at the next edge equals
    // the number of cycles the line stayed at the level in between.
    always_ff @(posedge clk) begin
        if (reset)            width <= '0;
        else if (fall | rise) width <= WCNT_W'(1);
        else if (~&width)     width <= width + WCNT_W'(1);
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: measures mark/space widths from the demodulator
// output, assembles LSB-first payload bits, checks the command inverse,
// handles repeat codes and presents frames on a valid/ready interface.
// Optional feature macro: IR_GLITCH_FILTER_EN (handled in nec_ir_width_meter).
// Ports:
//  nec_clk   in   sample clock, 1 tick = burst/BURST_TICKS
//  reset     in   synchronous, active-high
//  ir_signal in   raw receiver output, idle high, mark = low
//  word      out  last accepted frame, bit i = i-th received bit
//  addr      out  word[7:0]
//  cmd       out  command byte word[FRAME_BITS/2 +: 8]
//  rpt       out  1 = word was delivered by a repeat code
//  valid     out  frame available, outputs stable until accepted
//  ready     in   consumer accepts on valid && ready
//  err       out  one-cycle pulse on a rejected frame or timing violation
//  overrun   out  sticky, a completed frame was dropped because valid && !ready
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int FRAME_BITS    = 32,
    parameter int BURST_TICKS   = 10,
    parameter int TOL_PCT       = 25,
    parameter bit CHECK_INV     = 1'b1,
    parameter int RPT_WIN_TICKS = 2133
)(
    input  logic                  nec_clk,
    input  logic                  reset,
    input  logic                  ir_signal,
    output logic [FRAME_BITS-1:0] word,
    output logic [7:0]            addr,
    output logic [7:0]            cmd,
    output logic                  rpt,
    output logic                  valid,
    input  logic                  ready,
    output logic                  err,
    output logic                  overrun
);

    localparam int NOM_LEAD_MARK  = LEAD_MARK_B  * BURST_TICKS;
    localparam int NOM_LEAD_SPACE = LEAD_SPACE_B * BURST_TICKS;
    localparam int NOM_RPT_SPACE  = RPT_SPACE_B  * BURST_TICKS;
    localparam int NOM_BIT_MARK   = BIT_MARK_B   * BURST_TICKS;
    localparam int NOM_ZERO_SPACE = ZERO_SPACE_B * BURST_TICKS;
    localparam int NOM_ONE_SPACE  = ONE_SPACE_B  * BURST_TICKS;
    localparam int NOM_STOP_MARK  = STOP_MARK_B  * BURST_TICKS;
    localparam int IDLE_GAP       = IDLE_GAP_B   * BURST_TICKS;

    // Longest acceptable width per state; anything longer is a timeout.
    localparam int MAX_LEAD_MARK  = max_ok(NOM_LEAD_MARK,  TOL_PCT);
    localparam int MAX_LEAD_SPACE = max_ok(NOM_LEAD_SPACE, TOL_PCT);
    localparam int MAX_BIT_MARK   = max_ok(NOM_BIT_MARK,   TOL_PCT);
    localparam int MAX_BIT_SPACE  = max_ok(NOM_ONE_SPACE,  TOL_PCT);
    localparam int MAX_STOP_MARK  = max_ok(NOM_STOP_MARK,  TOL_PCT);

    localparam int BITCNT_W = $clog2(FRAME_BITS + 1);
    localparam int WIN_W    = $clog2(RPT_WIN_TICKS + 1);

    // Short frames have no room for a full command byte at FRAME_BITS/2,
    // and only 32-bit frames carry a separate inverse byte.
    localparam int CMD_LO        = (FRAME_BITS >= 16) ? FRAME_BITS / 2 : 0;
    localparam bit INV_CHECKABLE = (FRAME_BITS >= 32);
    localparam int INV_LO        = INV_CHECKABLE ? FRAME_BITS / 2 + 8 : CMD_LO;

    function automatic logic too_long(input logic [WCNT_W-1:0] w, input int lim);
        return (int'(w) > lim) || (&w);
    endfunction

    logic              level, fall, rise;
    logic [WCNT_W-1:0] width;

    nec_ir_width_meter u_meter (
        .clk    (nec_clk),
        .reset  (reset),
        .ir_raw (ir_signal),
        .level  (level),
        .fall   (fall),
        .rise   (rise),
        .width  (width)
    );

    nec_state_t              state, state_next;
    logic [FRAME_BITS-1:0]   shreg;
    logic [BITCNT_W-1:0]     bitcnt;
    logic                    is_rpt;
    logic                    win_open;
    logic [WIN_W-1:0]        win_cnt;
    logic                    inv_ok;
    logic err_next, shift_en, shift_bit, clr_bits, set_rpt, publish;

    always_comb begin
        inv_ok = 1'b1;
        if (INV_CHECKABLE) inv_ok = (shreg[CMD_LO +: 8] == ~shreg[INV_LO +: 8]);
    end

    always_ff @(posedge nec_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        shift_en   = 1'b0;
        shift_bit  = 1'b0;
        clr_bits   = 1'b0;
        set_rpt    = 1'b0;
        publish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) state_next = S_LEAD_MARK;
            end
            S_LEAD_MARK: begin
                if (rise) begin
                    if (tol_ok(width, NOM_LEAD_MARK, TOL_PCT)) state_next = S_LEAD_SPACE;
                    else begin err_next = 1'b1; state_next = S_WAIT_IDLE; end
                end else if (too_long(width, MAX_LEAD_MARK)) begin
                    err_next = 1'b1; state_next = S_WAIT_IDLE;
                end
            end
            S_LEAD_SPACE: begin
                if (fall) begin
                    if (tol_ok(width, NOM_LEAD_SPACE, TOL_PCT)) begin
                        clr_bits = 1'b1; state_next = S_BIT_MARK;
                    end else if (tol_ok(width, NOM_RPT_SPACE, TOL_PCT)) begin
                        set_rpt = 1'b1; state_next = S_RPT_STOP;
                    end else begin
                        err_next = 1'b1; state_next = S_WAIT_IDLE;
                    end
                end else if (too_long(width, MAX_LEAD_SPACE)) begin
                    err_next = 1'b1; state_next = S_WAIT_IDLE;
                end
            end
            S_BIT_MARK: begin
                if (rise) begin
                    if (tol_ok(width, NOM_BIT_MARK, TOL_PCT)) state_next = S_BIT_SPACE;
                    else begin err_next = 1'b1; state_next = S_WAIT_IDLE; end
                end else if (too_long(width, MAX_BIT_MARK)) begin
                    err_next = 1'b1; state_next = S_WAIT_IDLE;
                end
            end
            S_BIT_SPACE: begin
                // The falling edge that ends a space starts the next mark.
                if (fall) begin
                    if (tol_ok(width, NOM_ZERO_SPACE, TOL_PCT) || tol_ok(width, NOM_ONE_SPACE, TOL_PCT)) begin
                        shift_en   = 1'b1;
                        shift_bit  = tol_ok(width, NOM_ONE_SPACE, TOL_PCT);
                        state_next = (bitcnt == BITCNT_W'(FRAME_BITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
                    end else begin
                        err_next = 1'b1; state_next = S_WAIT_IDLE;
                    end
                end else if (too_long(width, MAX_BIT_SPACE)) begin
                    err_next = 1'b1; state_next = S_WAIT_IDLE;
                end
            end
            S_STOP_MARK, S_RPT_STOP: begin
                if (rise) begin
                    if (tol_ok(width, NOM_STOP_MARK, TOL_PCT)) state_next = S_DONE;
                    else begin err_next = 1'b1; state_next = S_WAIT_IDLE; end
                end else if (too_long(width, MAX_STOP_MARK)) begin
                    err_next = 1'b1; state_next = S_WAIT_IDLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                if (is_rpt) begin
                    if (win_open) publish = 1'b1;
                    else          err_next = 1'b1;
                end else if (CHECK_INV && !inv_ok) begin
                    err_next = 1'b1;
                end else begin
                    publish = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                // width restarts on every edge, so a stray fall restarts the quiet count
                if (level && (int'(width) >= IDLE_GAP)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Shift register: first received bit ends up in bit 0
    always_ff @(posedge nec_clk) begin
        if (shift_en) shreg <= {shift_bit, shreg[FRAME_BITS-1:1]};
    end

    always_ff @(posedge nec_clk) begin
        if (reset) begin
            bitcnt <= '0;
            is_rpt <= 1'b0;
        end else begin
            if (clr_bits)      bitcnt <= '0;
            else if (shift_en) bitcnt <= bitcnt + BITCNT_W'(1);
            if (clr_bits)      is_rpt <= 1'b0;
            else if (set_rpt)  is_rpt <= 1'b1;
        end
    end

    // Output stage: handshake, overrun and repeat window
    always_ff @(posedge nec_clk) begin
        if (reset) begin
            word     <= '0;
            rpt      <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            overrun  <= 1'b0;
            win_open <= 1'b0;
            win_cnt  <= '0;
        end else begin
            err <= err_next;
            if (valid && ready) valid <= 1'b0;
            if (publish) begin
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    if (!is_rpt) word <= shreg;
                    rpt   <= is_rpt;
                    valid <= 1'b1;
                end
                win_open <= 1'b1;
                win_cnt  <= '0;
            end else if (win_open) begin
                if (win_cnt == WIN_W'(RPT_WIN_TICKS - 1)) win_open <= 1'b0;
                else                                      win_cnt  <= win_cnt + WIN_W'(1);
            end
        end
    end

    assign addr = word[7:0];
    assign cmd  = word[CMD_LO +: 8];

endmodule
